// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs,
// anode-off pattern and the scan FSM state type.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph decoder;
// non-decimal nibbles render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with guard interval and
// per-frame input snapshot. Define LEADING_ZERO_BLANK_EN to dark leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [3:0]  dp_sel,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_LAST    = PW'(GUARD - 1);

    logic [PW-1:0] prescale_q;
    logic [1:0]    idx_q;
    scan_state_e   state_q;
    logic [15:0]   snap_q;
    logic [3:0]    an_q,  an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q,  dp_d;

    logic          tick;
    logic [6:0]    glyph;
    logic          lead_zero;
    logic          digit_on;

    assign tick = (prescale_q == PRESCALE_LAST);

    bcd_to_seg7 u_decode (
        .bcd_i (snap_q[{idx_q, 2'b00} +: 4]),
        .seg_o (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant digit are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd3:    lead_zero = (snap_q[15:12] == 4'd0);
            2'd2:    lead_zero = (snap_q[15:8]  == 8'd0);
            2'd1:    lead_zero = (snap_q[15:4]  == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        digit_on = (state_q == ST_DRIVE) && !blank && !lead_zero;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        if (digit_on) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = glyph;
            dp_d  = ~dp_sel[idx_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            idx_q      <= 2'd0;
            state_q    <= ST_GUARD;
            snap_q     <= 16'h0000;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;

            // Snapshot once per frame so a digit update never tears mid-frame.
            if (prescale_q == '0 && idx_q == 2'd0) begin
                snap_q <= data;
            end

            if (tick) begin
                prescale_q <= '0;
                idx_q      <= idx_q + 2'd1;
            end else begin
                prescale_q <= prescale_q + 1'b1;
            end

            case (state_q)
                ST_GUARD: if (prescale_q == GUARD_LAST) state_q <= ST_DRIVE;
                ST_DRIVE: if (tick)                     state_q <= ST_GUARD;
                default:                                state_q <= ST_GUARD;
            endcase
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a cycle-count reference model.
// Honours LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_scan_driver;

    localparam int R = 8;
    localparam int G = 2;
    localparam logic [11:0] OUT_OFF = {4'b1111, 7'b1111111, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp_sel = 4'h0;
    logic        blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int fails  = 0;

    // Reference model: cycle index since reset release and the frame snapshot.
    int          t = 0;
    logic [15:0] snap_m = 16'h0000;
    logic [11:0] exp_o = OUT_OFF;
    logic [6:0]  glyph [16];

    seg7_scan_driver #(.REFRESH_DIV(R), .GUARD(G)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .dp_sel (dp_sel),
        .blank  (blank),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
        for (int k = 10; k < 16; k++) glyph[k] = 7'b0111111;
    end

    // What the display must show for the cycle with index tt and the given inputs.
    function automatic logic [11:0] expect_out(int tt, logic [15:0] s, logic b, logic [3:0] dps);
        int          p = tt % R;
        int          d = (tt / R) % 4;
        logic        off = (p < G) || b;
        logic [3:0]  nib = s[4*d +: 4];
        logic [3:0]  an_e;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (s >> (4*d)) == 16'h0000) off = 1'b1;
`endif
        if (off) return OUT_OFF;
        an_e = 4'b0001 << d;
        return {~an_e, glyph[nib], ~dps[d]};
    endfunction

    // Advance one clock; afterwards exp_o is what the outputs must show.
    task automatic step();
        logic [11:0] nxt;
        logic [15:0] snap_n;
        int          t_n;
        snap_n = snap_m;
        if (reset) begin
            nxt    = OUT_OFF;
            snap_n = 16'h0000;
            t_n    = 0;
        end else begin
            nxt = expect_out(t, snap_m, blank, dp_sel);
            if (t % (4*R) == 0) snap_n = data;
            t_n = t + 1;
        end
        @(posedge clk);
        #1;
        exp_o  = nxt;
        snap_m = snap_n;
        t      = t_n;
    endtask

    task automatic align_frame();
        for (int k = 0; k < 4*R && (t % (4*R)) != 0; k++) step();
    endtask

    task automatic test_reset();
        data = $urandom();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({an, seg, dp} !== OUT_OFF) begin
                fails++;
                $display("FAIL reset_values: got an=%b seg=%b dp=%b, want 1111/1111111/1", an, seg, dp);
            end
        end
        data   = 16'h1234;
        dp_sel = 4'b0000;
        reset  = 1'b0;
        step();
        checks++;
        if (an !== 4'b1111) begin
            fails++;
            $display("FAIL first_after_release: got an=%b want 1111", an);
        end
    endtask

    task automatic test_scan_frame();
        int cnt [4];
        int dark = 0;
        logic [6:0] want_seg [4];
        want_seg[0] = 7'b0011001; want_seg[1] = 7'b0110000;
        want_seg[2] = 7'b0100100; want_seg[3] = 7'b1111001;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        for (int k = 0; k < 4*R; k++) begin
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL scan_frame t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
            if (an === 4'b1111) dark++;
            for (int d = 0; d < 4; d++)
                if (an === ~(4'b0001 << d) && seg === want_seg[d]) cnt[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cnt[d] != R - G) begin
                fails++;
                $display("FAIL scan_digit%0d_cycles: got %0d want %0d", d, cnt[d], R - G);
            end
        end
        checks++;
        if (dark != 4*G) begin
            fails++;
            $display("FAIL scan_dark_cycles: got %0d want %0d", dark, 4*G);
        end
    endtask

    task automatic test_data_change();
        int base;
        int d3_one = 0;
        int d3_five = 0;
        data = 16'h1234;
        align_frame();
        base = t;
        for (int k = 0; k < 8*R; k++) begin
            if (t - base == 10) data = 16'h5678;
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL data_change t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
            if (an === 4'b0111 && seg === 7'b1111001) d3_one++;
            if (an === 4'b0111 && seg === 7'b0010010) d3_five++;
        end
        checks++;
        if (d3_one != R - G || d3_five != R - G) begin
            fails++;
            $display("FAIL no_tearing: digit3 showed 1 for %0d and 5 for %0d cycles, want %0d each",
                     d3_one, d3_five, R - G);
        end
    endtask

    task automatic test_dash_dp();
        int dash_dp = 0;
        int seven = 0;
        int upper = 0;
        int want_upper;
        data   = 16'h00A7;
        dp_sel = 4'b0010;
        step();
        align_frame();
        for (int k = 0; k < 4*R; k++) begin
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL dash_dp t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
            if (an === 4'b1101 && seg === 7'b0111111 && dp === 1'b0) dash_dp++;
            if (an === 4'b1110 && seg === 7'b1111000 && dp === 1'b1) seven++;
            if (an[3] === 1'b0 || an[2] === 1'b0) upper++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        want_upper = 0;
`else
        want_upper = 2*(R - G);
`endif
        checks++;
        if (dash_dp != R - G) begin
            fails++;
            $display("FAIL dash_with_dp: got %0d cycles want %0d", dash_dp, R - G);
        end
        checks++;
        if (seven != R - G) begin
            fails++;
            $display("FAIL digit0_seven: got %0d cycles want %0d", seven, R - G);
        end
        checks++;
        if (upper != want_upper) begin
            fails++;
            $display("FAIL upper_digits_lit: got %0d cycles want %0d", upper, want_upper);
        end
    endtask

    task automatic test_zero();
        int lit = 0;
        int zero0 = 0;
        int want_lit;
        data   = 16'h0000;
        dp_sel = 4'b0000;
        step();
        align_frame();
        for (int k = 0; k < 4*R; k++) begin
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL zero t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
            if (an !== 4'b1111) lit++;
            if (an === 4'b1110 && seg === 7'b1000000) zero0++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        want_lit = R - G;
`else
        want_lit = 4*(R - G);
`endif
        checks++;
        if (lit != want_lit || zero0 != R - G) begin
            fails++;
            $display("FAIL zero_lit_cycles: got lit=%0d digit0=%0d want %0d/%0d", lit, zero0, want_lit, R - G);
        end
    endtask

    task automatic test_blank();
        data = 16'h4321;
        for (int k = 0; k < 4*R && (t % R) != G; k++) step();
        blank = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (an !== 4'b1111 || {an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL blank_dark t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
        end
        blank = 1'b0;
        step();
        checks++;
        if (an === 4'b1111 || {an, seg, dp} !== exp_o) begin
            fails++;
            $display("FAIL blank_resume t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        data = 16'h1111;
        for (int k = 0; k < 8*R && !(((t / R) % 4) == 2 && (t % R) == 4); k++) step();
        data  = 16'h9876;
        reset = 1'b1;
        step();
        checks++;
        if ({an, seg, dp} !== OUT_OFF) begin
            fails++;
            $display("FAIL reset_mid_values: got %b/%b/%b want %b", an, seg, dp, OUT_OFF);
        end
        reset = 1'b0;
        for (int k = 0; k < 2*R && !found; k++) begin
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL reset_mid t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
            if (an !== 4'b1111) found = 1;
        end
        checks++;
        if (!found || an !== 4'b1110 || seg !== 7'b0000010) begin
            fails++;
            $display("FAIL reset_mid_first_digit: got an=%b seg=%b want 1110/0000010", an, seg);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40*R; k++) begin
            if ($urandom_range(0, 6) == 0) data = $urandom();
            if ($urandom_range(0, 9) == 0) dp_sel = 4'($urandom());
            blank = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) data[15:4] = 12'h000;
            step();
            checks++;
            if ({an, seg, dp} !== exp_o) begin
                fails++;
                $display("FAIL random t=%0d: got %b/%b/%b want %b", t, an, seg, dp, exp_o);
            end
        end
        blank = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan_frame();
        test_data_change();
        test_dash_dp();
        test_zero();
        test_blank();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
